// File: rtl/st_data_buffer_pkg.sv
// Shared types for the store-data path: register tags and data, store offsets,
// branch broadcast and the lookup/result/atomic uop structs.
package st_data_buffer_pkg;

  typedef logic [6:0]  RFTag;   // bit 6 set: tag[5:0] is a sign-extended immediate
  typedef logic [31:0] RegT;
  typedef logic [1:0]  StOff_t;

  typedef struct packed {
    logic       taken;
    logic       flush;
    logic [6:0] storeSqN;
  } BranchProv;

  typedef struct packed {
    RFTag       tag;
    logic [6:0] storeSqN;
    StOff_t     offs;
    logic       valid;
  } StDataLookupUOp;

  typedef struct packed {
    logic       valid;
    logic [6:0] storeSqN;
    RegT        data;
  } StDataUOp;

  typedef struct packed {
    logic       valid;
    logic [6:0] storeSqN;
    RegT        result;
  } AMO_Data_UOp;

endpackage

// File: rtl/st_data_fifo.sv
// One lane of store data: in-order storage with wrap-around pointers and
// branch truncation of the youngest entries. ST_DATA_BYPASS_EN adds empty-FIFO bypass.
module st_data_fifo
  import st_data_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  BranchProv   branch_i,
  input  logic        enq_valid_i,
  input  logic [6:0]  enq_sqn_i,
  input  RegT         enq_data_i,
  input  logic        deq_block_i,
  output StDataUOp    head_o,
  output logic [PW:0] count_o
);

  logic [PW:0]   wr_q, rd_q, wr_d, rd_d, survivors;
  logic [PW-1:0] waddr;
  logic [6:0]    sqn_q  [DEPTH];
  RegT           data_q [DEPTH];
  logic          head_live, enq_live, bypass, wr_en;

  // Younger than the branch means a strictly positive wrapped distance.
  function automatic logic killed(input BranchProv b, input logic [6:0] sqn);
    logic [6:0] age;
    age = sqn - b.storeSqN;
    return b.taken && (b.flush || (!age[6] && age != 7'd0));
  endfunction

  assign count_o = wr_q - rd_q;

  // NOTE: every signal assigned here gets a value on every path before any
  // condition, so no latch can be inferred.
  always_comb begin
    survivors = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < count_o && !killed(branch_i, sqn_q[rd_q[PW-1:0] + PW'(i)]))
        survivors = survivors + 1'b1;
    end
    head_live = survivors != '0;
    enq_live  = enq_valid_i && !killed(branch_i, enq_sqn_i);
`ifdef ST_DATA_BYPASS_EN
    bypass    = enq_live && !head_live && !deq_block_i;
`else
    bypass    = 1'b0;
`endif
    wr_en = enq_live && !bypass;
    // Entries are age-ordered, so survivors form a prefix: truncate the tail.
    waddr = rd_q[PW-1:0] + survivors[PW-1:0];
    wr_d  = rd_q + survivors + (PW+1)'(wr_en);
    rd_d  = rd_q + (PW+1)'(head_live && !deq_block_i);

    head_o.valid    = head_live || bypass;
    head_o.storeSqN = bypass ? enq_sqn_i  : sqn_q[rd_q[PW-1:0]];
    head_o.data     = bypass ? enq_data_i : data_q[rd_q[PW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is not reset; pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sqn_q[waddr]  <= enq_sqn_i;
      data_q[waddr] <= enq_data_i;
    end
  end

endmodule

// File: rtl/st_data_buffer.sv
// Store-data buffer: per lane, looks up register/immediate store data, aligns it
// and queues it for the store queue; atomics preempt. ST_DATA_BYPASS_EN cuts latency to 1.
module st_data_buffer
  import st_data_buffer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  BranchProv        IN_branch,
  input  StDataLookupUOp   IN_uop [WIDTH],
  output logic [WIDTH-1:0] OUT_ready,
  input  AMO_Data_UOp      IN_atomicUOp [WIDTH],
  output RFTag             OUT_readTag [WIDTH],
  input  RegT              IN_readData [WIDTH],
  input  logic [WIDTH-1:0] IN_stall,
  output StDataUOp         OUT_uop [WIDTH]
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] inflight_q, accept;
  logic [6:0]       if_sqn_q  [WIDTH];
  RFTag             if_tag_q  [WIDTH];
  StOff_t           if_offs_q [WIDTH];
  RegT              enq_data  [WIDTH];
  StDataUOp         head      [WIDTH];
  logic [PW:0]      count     [WIDTH];

  function automatic logic killed(input BranchProv b, input logic [6:0] sqn);
    logic [6:0] age;
    age = sqn - b.storeSqN;
    return b.taken && (b.flush || (!age[6] && age != 7'd0));
  endfunction

  function automatic RegT align(input RegT d, input StOff_t offs);
    return d << {offs, 3'b000};
  endfunction

  always_comb begin
    for (int l = 0; l < WIDTH; l++) begin
      OUT_readTag[l] = IN_uop[l].tag;
      // Count in-flight lookups so an accepted uop always finds a slot.
      OUT_ready[l]   = (PW+2)'(count[l]) + (PW+2)'(inflight_q[l]) < (PW+2)'(DEPTH);
      accept[l]      = IN_uop[l].valid && OUT_ready[l] && !killed(IN_branch, IN_uop[l].storeSqN);
      enq_data[l]    = align(if_tag_q[l][6] ? {{26{if_tag_q[l][5]}}, if_tag_q[l][5:0]}
                                            : IN_readData[l], if_offs_q[l]);
      if (IN_atomicUOp[l].valid) begin
        OUT_uop[l].valid    = 1'b1;
        OUT_uop[l].storeSqN = IN_atomicUOp[l].storeSqN;
        OUT_uop[l].data     = IN_atomicUOp[l].result;
      end else begin
        OUT_uop[l] = head[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= accept;
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < WIDTH; l++) begin
      if (accept[l]) begin
        if_sqn_q[l]  <= IN_uop[l].storeSqN;
        if_tag_q[l]  <= IN_uop[l].tag;
        if_offs_q[l] <= IN_uop[l].offs;
      end
    end
  end

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    st_data_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .branch_i    (IN_branch),
      .enq_valid_i (inflight_q[l]),
      .enq_sqn_i   (if_sqn_q[l]),
      .enq_data_i  (enq_data[l]),
      .deq_block_i (IN_stall[l] || IN_atomicUOp[l].valid),
      .head_o      (head[l]),
      .count_o     (count[l])
    );
  end

endmodule

// File: tb/tb_st_data_buffer.sv
// Self-checking bench for st_data_buffer: directed scenarios plus random traffic
// against a queue-based reference model of each lane.
module tb_st_data_buffer;
  import st_data_buffer_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  BranchProv        branch;
  StDataLookupUOp   uop       [WIDTH];
  logic [WIDTH-1:0] ready;
  AMO_Data_UOp      amo       [WIDTH];
  RFTag             read_tag  [WIDTH];
  RegT              read_data [WIDTH];
  logic [WIDTH-1:0] stall;
  StDataUOp         out_uop   [WIDTH];

  st_data_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .IN_branch(branch), .IN_uop(uop), .OUT_ready(ready),
    .IN_atomicUOp(amo), .OUT_readTag(read_tag), .IN_readData(read_data),
    .IN_stall(stall), .OUT_uop(out_uop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected entries per lane with a mask of meaningful bits.
  typedef struct packed {
    logic [6:0]  sqn;
    logic [31:0] val;
    logic [31:0] mask;
  } exp_t;

  exp_t       fifo_m    [WIDTH][$];
  logic [6:0] taken_log [WIDTH][$];
  logic       pend_v    [WIDTH];
  logic [6:0] pend_sqn  [WIDTH];
  RFTag       pend_tag  [WIDTH];
  StOff_t     pend_offs [WIDTH];
  int unsigned gsqn = 60;

  function automatic bit killed(input logic [6:0] sqn);
    logic signed [6:0] age;
    age = sqn - branch.storeSqN;
    return branch.taken && (branch.flush || age > 7'sd0);
  endfunction

  function automatic exp_t make_entry(input logic [6:0] sqn, input RFTag tag,
                                      input StOff_t offs, input RegT rd);
    RegT  v;
    exp_t e;
    v = tag[6] ? 32'($signed(tag[5:0])) : rd;
    e.sqn = sqn;
    case (offs)
      2'd0:    begin e.mask = 32'hFFFF_FFFF; e.val = v;                      end
      2'd1:    begin e.mask = 32'h0000_FF00; e.val = {16'h0, v[7:0], 8'h0};  end
      2'd2:    begin e.mask = 32'hFFFF_0000; e.val = {v[15:0], 16'h0};       end
      default: begin e.mask = 32'hFF00_0000; e.val = {v[7:0], 24'h0};        end
    endcase
    return e;
  endfunction

  function automatic bit model_ready(input int l);
    return (fifo_m[l].size() + (pend_v[l] ? 1 : 0)) < DEPTH;
  endfunction

  task automatic model_view(input int l, output bit ev, output exp_t ee, output bit byp);
    ev = 1'b0; ee = '0; byp = 1'b0;
    for (int i = 0; i < fifo_m[l].size(); i++) begin
      if (!ev && !killed(fifo_m[l][i].sqn)) begin
        ev = 1'b1;
        ee = fifo_m[l][i];
      end
    end
`ifdef ST_DATA_BYPASS_EN
    if (!ev && pend_v[l] && !killed(pend_sqn[l]) && !stall[l] && !amo[l].valid) begin
      byp = 1'b1;
      ev  = 1'b1;
      ee  = make_entry(pend_sqn[l], pend_tag[l], pend_offs[l], read_data[l]);
    end
`endif
    if (amo[l].valid) begin
      ev = 1'b1;
      ee = '{sqn: amo[l].storeSqN, val: amo[l].result, mask: 32'hFFFF_FFFF};
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < WIDTH; l++) begin
      fifo_m[l].delete();
      pend_v[l] = 1'b0;
    end
  endtask

  task automatic compare_all();
    bit   ev, byp;
    exp_t ee;
    for (int l = 0; l < WIDTH; l++) begin
      model_view(l, ev, ee, byp);
      check($sformatf("ready%0d", l), ready[l], model_ready(l));
      check($sformatf("tag%0d", l), read_tag[l], uop[l].tag);
      check($sformatf("valid%0d", l), out_uop[l].valid, ev);
      if (ev) begin
        check($sformatf("sqn%0d", l), out_uop[l].storeSqN, ee.sqn);
        check($sformatf("data%0d", l), out_uop[l].data & ee.mask, ee.val);
      end
      if (out_uop[l].valid && !stall[l]) taken_log[l].push_back(out_uop[l].storeSqN);
    end
  endtask

  task automatic model_update();
    bit   ev, byp, rdy;
    exp_t ee;
    exp_t keep[$];
    if (rst) begin
      model_reset();
      return;
    end
    for (int l = 0; l < WIDTH; l++) begin
      model_view(l, ev, ee, byp);
      rdy = model_ready(l);
      keep = {};
      for (int i = 0; i < fifo_m[l].size(); i++)
        if (!killed(fifo_m[l][i].sqn)) keep.push_back(fifo_m[l][i]);
      fifo_m[l] = keep;
      if (fifo_m[l].size() > 0 && !stall[l] && !amo[l].valid) void'(fifo_m[l].pop_front());
      if (pend_v[l] && !killed(pend_sqn[l]) && !byp)
        fifo_m[l].push_back(make_entry(pend_sqn[l], pend_tag[l], pend_offs[l], read_data[l]));
      pend_v[l]    = uop[l].valid && rdy && !killed(uop[l].storeSqN);
      pend_sqn[l]  = uop[l].storeSqN;
      pend_tag[l]  = uop[l].tag;
      pend_offs[l] = uop[l].offs;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    branch = '0;
    stall  = '0;
    for (int l = 0; l < WIDTH; l++) begin
      uop[l]       = '0;
      amo[l]       = '0;
      read_data[l] = '0;
    end
  endtask

  task automatic check_out(input int l, input logic [6:0] sqn, input RegT mask,
                           input RegT val, input string name);
    check({name, "_valid"}, out_uop[l].valid, 1'b1);
    check({name, "_sqn"}, out_uop[l].storeSqN, sqn);
    check({name, "_data"}, out_uop[l].data & mask, val);
  endtask

  task automatic single_uop(input int l, input logic [6:0] sqn, input RFTag tag, input StOff_t offs,
                            input RegT rd, input RegT mask, input RegT val, input string name);
    drive_idle();
    uop[l] = '{tag: tag, storeSqN: sqn, offs: offs, valid: 1'b1};
    run_cycle();
    drive_idle();
    read_data[l] = rd;
`ifdef ST_DATA_BYPASS_EN
    #1 check_out(l, sqn, mask, val, name);
    run_cycle();
`else
    run_cycle();
    drive_idle();
    #1 check_out(l, sqn, mask, val, name);
`endif
    run_cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) run_cycle();
    check("rst_ready", ready, 2'b11);
    check("rst_valid", {out_uop[1].valid, out_uop[0].valid}, 2'b00);
    rst = 1'b0;

    // Register operand, byte lane 1; immediate all-ones operand.
    single_uop(0, 7'd20, 7'd5,   2'd1, 32'h0000_00AB, 32'h0000_FF00, 32'h0000_AB00, "reg_byte");
    single_uop(1, 7'd21, 7'h7F,  2'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "imm_ones");
    single_uop(0, 7'd22, 7'd9,   2'd2, 32'hCAFE_1357, 32'hFFFF_0000, 32'h1357_0000, "reg_half");

    // Backpressure: six issues into a stalled lane, only DEPTH survive.
    drive_idle();
    taken_log[0].delete();
    for (int k = 0; k < 6; k++) begin
      drive_idle();
      stall[0] = 1'b1;
      uop[0] = '{tag: 7'd1, storeSqN: 7'(30 + k), offs: 2'd0, valid: 1'b1};
      read_data[0] = 32'(k);
      run_cycle();
    end
    drive_idle();
    stall[0] = 1'b1;
    #1 check("full_ready", ready[0], 1'b0);
    drive_idle();
    repeat (8) run_cycle();
    check("full_drain_cnt", taken_log[0].size(), 4);
    for (int i = 0; i < 4 && i < taken_log[0].size(); i++)
      check($sformatf("full_drain_%0d", i), taken_log[0][i], 7'(30 + i));

    // Branch keeps only the entry at or older than its storeSqN.
    for (int k = 0; k < 4; k++) begin
      drive_idle();
      stall[0] = 1'b1;
      if (k < 3) uop[0] = '{tag: 7'd2, storeSqN: 7'(10 + k), offs: 2'd0, valid: 1'b1};
      run_cycle();
    end
    drive_idle();
    stall[0] = 1'b1;
    branch = '{taken: 1'b1, flush: 1'b0, storeSqN: 7'd10};
    run_cycle();
    drive_idle();
    stall[0] = 1'b1;
    #1 check_out(0, 7'd10, 32'h0, 32'h0, "branch_head");
    taken_log[0].delete();
    drive_idle();
    repeat (4) run_cycle();
    check("branch_left_cnt", taken_log[0].size(), 1);
    if (taken_log[0].size() > 0) check("branch_left_sqn", taken_log[0][0], 7'd10);

    // Flush empties the lane.
    for (int k = 0; k < 4; k++) begin
      drive_idle();
      stall[0] = 1'b1;
      if (k < 3) uop[0] = '{tag: 7'd3, storeSqN: 7'(20 + k), offs: 2'd0, valid: 1'b1};
      run_cycle();
    end
    drive_idle();
    stall[0] = 1'b1;
    branch = '{taken: 1'b1, flush: 1'b1, storeSqN: 7'd30};
    run_cycle();
    drive_idle();
    stall[0] = 1'b1;
    #1 check("flush_valid", out_uop[0].valid, 1'b0);
    check("flush_ready", ready[0], 1'b1);
    run_cycle();

    // Atomic result preempts a waiting head without consuming it.
    drive_idle();
    stall[1] = 1'b1;
    uop[1] = '{tag: 7'd4, storeSqN: 7'd40, offs: 2'd0, valid: 1'b1};
    run_cycle();
    drive_idle();
    stall[1] = 1'b1;
    read_data[1] = 32'h0BAD_F00D;
    run_cycle();
    for (int k = 0; k < 2; k++) begin
      drive_idle();
      amo[1] = '{valid: 1'b1, storeSqN: 7'd7, result: 32'hDEAD_BEEF};
      #1 check_out(1, 7'd7, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "amo");
      run_cycle();
    end
    drive_idle();
    #1 check_out(1, 7'd40, 32'hFFFF_FFFF, 32'h0BAD_F00D, "amo_after");
    run_cycle();
    drive_idle();
    #1 check("amo_drained", out_uop[1].valid, 1'b0);
    run_cycle();

    // Asynchronous reset with three queued entries and one in flight.
    for (int k = 0; k < 4; k++) begin
      drive_idle();
      stall[0] = 1'b1;
      uop[0] = '{tag: 7'd6, storeSqN: 7'(50 + k), offs: 2'd0, valid: 1'b1};
      run_cycle();
    end
    drive_idle();
    #1 check("pre_rst_ready", ready[0], 1'b0);
    #1 rst = 1'b1;
    model_reset();
    #1 check("async_rst_valid", out_uop[0].valid, 1'b0);
    check("async_rst_ready", ready[0], 1'b1);
    run_cycle();
    rst = 1'b0;
    repeat (3) run_cycle();
    check("post_rst_valid", out_uop[0].valid, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive_idle();
      for (int l = 0; l < WIDTH; l++) begin
        if ($urandom_range(0, 9) < 6) begin
          uop[l] = '{tag: 7'($urandom), storeSqN: 7'(gsqn), offs: 2'($urandom), valid: 1'b1};
          gsqn++;
        end
        read_data[l] = $urandom;
        stall[l]     = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 9) == 0)
          amo[l] = '{valid: 1'b1, storeSqN: 7'($urandom), result: $urandom};
      end
      if ($urandom_range(0, 15) == 0)
        branch = '{taken: 1'b1, flush: $urandom_range(0, 3) == 0,
                   storeSqN: 7'(gsqn - $urandom_range(1, 12))};
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/st_data_buffer.md
ST_DATA_BUFFER -- requirements
Module: st_data_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of independent store-data lanes.
REQ-002 SHALL have parameter DEPTH, default 4, power of two >= 2: per-lane buffer entries.
REQ-003 SHALL have port clk  input  1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port IN_branch  input  BranchProv: branch/flush broadcast.
REQ-006 SHALL have port IN_uop  input  StDataLookupUOp[WIDTH]: store-data lookups (tag, storeSqN, offs, valid).
REQ-007 SHALL have port OUT_ready  output  1[WIDTH]: lane accepts IN_uop this cycle.
REQ-008 SHALL have port IN_atomicUOp  input  AMO_Data_UOp[WIDTH]: AMO results, highest priority.
REQ-009 SHALL have port OUT_readTag  output  RFTag[WIDTH]: register-file read address.
REQ-010 SHALL have port IN_readData  input  RegT[WIDTH]: register-file data, one cycle after OUT_readTag.
REQ-011 SHALL have port IN_stall  input  1[WIDTH]: consumer backpressure; OUT_uop not taken while high.
REQ-012 SHALL have port OUT_uop  output  StDataUOp[WIDTH]: store data (valid, storeSqN, data) to store queue.

Function
REQ-013 Per lane, SHALL accept IN_uop when valid && OUT_ready && not killed by IN_branch (kill: taken && (flush || signed(storeSqN - branch.storeSqN) > 0)).
REQ-014 OUT_readTag SHALL equal IN_uop.tag combinationally, every cycle.
REQ-015 Accepted uop with tag MSB set SHALL use immediate {26{tag[5]}, tag[5:0]}; otherwise IN_readData of the following cycle.
REQ-016 Data SHALL be shifted by offs: 0 none, 1 byte to [15:8], 2 half to [31:16], 3 byte to [31:24]; unused bits don't-care.
REQ-017 Accepted uop SHALL enter per-lane in-order FIFO one cycle after accept (cycle A+1), data captured then.
REQ-018 OUT_ready SHALL be (occupancy + in-flight) < DEPTH, registered-state only, no dependence on IN_stall.
REQ-019 OUT_uop SHALL be IN_atomicUOp when its valid is set (data = result), FIFO head otherwise, invalid if FIFO empty.
REQ-020 FIFO SHALL dequeue head iff head valid && !IN_stall && !IN_atomicUOp.valid.
REQ-021 On branch taken SHALL drop in-flight and FIFO entries satisfying REQ-013 kill condition, same cycle, keeping older entries in order; flush drops all.
REQ-022 Simultaneous enqueue, dequeue and kill SHALL apply kill first, then dequeue, then enqueue of survivors.
REQ-023 Pointers SHALL wrap modulo DEPTH; full and empty distinguished by an extra pointer bit.
REQ-024 No enqueue SHALL be lost: full never coincides with an in-flight entry lacking a slot.

Reset
REQ-025 rst SHALL asynchronously clear pointers, in-flight flags, and FIFO valids; OUT_uop.valid=0 and OUT_ready=1 during and after reset unless IN_atomicUOp drives OUT_uop.
REQ-026 rst mid-operation SHALL discard all buffered and in-flight data with no output in the next cycle.

Configuration
REQ-027 Macro ST_DATA_BYPASS_EN defined: at cycle A+1 with FIFO empty, no atomic, !IN_stall, the arriving entry SHALL appear on OUT_uop combinationally and not be written (latency 1).
REQ-028 Macro undefined: entry SHALL first appear on OUT_uop at cycle A+2 (latency 2); no combinational IN_readData-to-OUT_uop path.

Structure
REQ-029 StDataLookupUOp, StDataUOp, AMO_Data_UOp, BranchProv, RFTag, RegT, StOff_t SHALL come from the shared package; nothing new added there.
REQ-030 One sub-module st_data_fifo (one lane: storage, pointers, age-based truncation) SHALL be instantiated WIDTH times; shifting stays in st_data_buffer as a function.

Verification
REQ-031 Lane 0 uop tag=5 (reg), offs=1, IN_readData=0x000000AB -> OUT_uop data[15:8]=0xAB, storeSqN matched, at A+2 (A+1 with bypass).
REQ-032 Immediate tag with MSB set, tag[5:0]=0x3F, offs=0 -> data=0xFFFFFFFF.
REQ-033 DEPTH=4, IN_stall=1, issue 6 uops -> OUT_ready low after 4 accepts; release stall -> 4 outputs in storeSqN order, none lost.
REQ-034 FIFO holds storeSqN 10,11,12; branch taken storeSqN=10 no flush -> only 10 remains; flush=1 -> empty next cycle.
REQ-035 IN_atomicUOp valid storeSqN=7 while FIFO head valid -> OUT_uop=atomic; head held; emitted after atomic drops.
REQ-036 rst asserted with 3 entries and one in flight -> OUT_uop.valid=0, OUT_ready=1 immediately; no stale output after release.
